// File: rtl/hmmm_loader.sv
// hmmm_loader: streams a host program into hmmm core memory, boots the core, then services its I/O bus.
// Optional HMMM_LOADER_CKSUM_EN builds a 16-bit additive checksum of the loaded words.
module hmmm_loader #(
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              host_valid,
  input  logic [15:0]       host_data,
  output logic              host_ready,
  output logic              core_rst,
  output logic              pgrm_addr,
  output logic              pgrm_data,
  output logic [15:0]       bus_out,
  output logic              bus_oe,
  input  logic [15:0]       bus_in,
  input  logic              core_read,
  input  logic              core_write,
  input  logic              core_halt,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              underflow,
  output logic [15:0]       checksum
);
  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, BOOT, RUN, HALTED} state_t;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(PROG_DEPTH);
  state_t state;
  logic [ADDR_W:0] addr, len_q, len_c, addr_nx;
  logic [15:0] word;
  logic idle_like, accept;
  assign idle_like = state == IDLE || state == HALTED;
  assign accept = state == WAIT && host_valid;
  assign len_c = len > DEPTH ? DEPTH : len;
  assign addr_nx = addr + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      len_q <= '0;
      word <= '0;
      underflow <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, HALTED: if (start) begin
          len_q <= len_c;
          addr <= '0;
          underflow <= 1'b0;
          state <= len_c == '0 ? BOOT : WAIT;
        end
        WAIT: if (host_valid) begin
          word <= host_data;
          state <= ADDR;
        end
        ADDR: state <= DATA;
        DATA: begin
          addr <= addr_nx;
          state <= addr_nx == len_q ? BOOT : WAIT;
        end
        BOOT: state <= RUN;
        RUN: begin
          if (core_read && !in_valid) underflow <= 1'b1;
          if (core_write) begin
            out_data <= bus_in;
            out_valid <= 1'b1;
          end
          if (core_halt) state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Read service is combinational so the core sees input data in the same cycle it asks.
  always_comb begin
    host_ready = state == WAIT;
    core_rst = state == IDLE || state == BOOT;
    pgrm_addr = state == ADDR;
    pgrm_data = state == DATA;
    bus_oe = state == ADDR || state == DATA || (state == RUN && core_read);
    bus_out = state == ADDR ? 16'(addr) :
              state == DATA ? word :
              state == RUN  ? (in_valid ? in_data : 16'h0000) : 16'h0000;
    in_ready = state == RUN && core_read && in_valid;
    busy = !idle_like;
    done = state == HALTED;
  end
`ifdef HMMM_LOADER_CKSUM_EN
  logic [15:0] sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum <= '0;
    else if (idle_like && start) sum <= '0;
    else if (accept) sum <= sum + host_data;
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_hmmm_loader.sv
// tb_hmmm_loader: directed + randomized bench for hmmm_loader against a transaction-level model.
module tb_hmmm_loader;
  localparam int PD = 256;
  localparam int AW = 8;
  logic clk = 0, rst_n = 0, start = 0, host_valid = 0, host_ready;
  logic [AW:0] len = 0;
  logic [15:0] host_data = 0, bus_out, bus_in = 0, in_data = 0, out_data, checksum;
  logic core_rst, pgrm_addr, pgrm_data, bus_oe, core_read = 0, core_write = 0, core_halt = 0;
  logic in_valid = 0, in_ready, out_valid, busy, done, underflow;
  int compared = 0, mismatched = 0;
  logic [15:0] prog[$], aq[$], dq[$];
  logic [15:0] exp_ck;
  logic uf_m;

  hmmm_loader #(.PROG_DEPTH(PD), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .host_valid(host_valid),
    .host_data(host_data), .host_ready(host_ready), .core_rst(core_rst),
    .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .core_read(core_read), .core_write(core_write), .core_halt(core_halt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .done(done), .underflow(underflow), .checksum(checksum));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record every strobe pair seen on the bus; the load task compares them to the program.
  always @(negedge clk) if (rst_n) begin
    if (pgrm_addr) aq.push_back(bus_out);
    if (pgrm_data) dq.push_back(bus_out);
    if (pgrm_addr || pgrm_data) chk("strobe_oe", bus_oe, 1);
  end

  function automatic logic [15:0] exp_sum();
    logic [15:0] s = 0;
`ifdef HMMM_LOADER_CKSUM_EN
    foreach (prog[i]) s += prog[i];
`endif
    return s;
  endfunction

  task automatic load(input int l, input bit gaps);
    int n = l > PD ? PD : l;
    while (prog.size() < n) prog.push_back(16'($urandom));
    while (prog.size() > n) void'(prog.pop_back());
    aq.delete();
    dq.delete();
    uf_m = 0;
    start = 1;
    len = (AW+1)'(l);
    tick();
    start = 0;
    chk("cksum_clear", checksum, 0);
    chk("busy_load", busy, 1);
    if (n == 0) begin
      chk("len0_boot_rst", core_rst, 1);
      tick();
      chk("len0_run_rst", core_rst, 0);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        chk("ready_wait", host_ready, 1);
        tick();
      end
      host_valid = 1;
      host_data = prog[i];
      chk("ready", host_ready, 1);
      chk("wait_rst", core_rst, 0);
      tick();
      host_valid = 0;
      host_data = 16'($urandom);
      chk("addr_strobe", pgrm_addr, 1);
      chk("ready_low", host_ready, 0);
      tick();
      chk("data_strobe", pgrm_data, 1);
      tick();
      if (i == n - 1) begin
        chk("boot_pulse", core_rst, 1);
        chk("boot_busy", busy, 1);
        tick();
        chk("run_rst", core_rst, 0);
      end
    end
    exp_ck = exp_sum();
    chk("n_addr", aq.size(), n);
    chk("n_data", dq.size(), n);
    for (int i = 0; i < n && i < aq.size() && i < dq.size(); i++) begin
      chk("pair_addr", aq[i], i);
      chk("pair_data", dq[i], prog[i]);
    end
    chk("cksum", checksum, exp_ck);
  endtask

  task automatic run_random(input int cycles);
    logic pw;
    logic [15:0] pd;
    for (int c = 0; c < cycles; c++) begin
      core_read = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = 16'($urandom);
      core_write = 1'($urandom);
      bus_in = 16'($urandom);
      #1;
      chk("rd_oe", bus_oe, core_read);
      chk("rd_bus", bus_out, in_valid ? in_data : 16'h0);
      chk("rd_pop", in_ready, core_read && in_valid);
      if (core_read && !in_valid) uf_m = 1;
      pw = core_write;
      pd = bus_in;
      tick();
      chk("wr_valid", out_valid, pw);
      if (pw) chk("wr_data", out_data, pd);
      chk("underflow", underflow, uf_m);
      chk("run_busy", busy, 1);
    end
    core_read = 0;
    in_valid = 0;
    core_write = 0;
  endtask

  task automatic halt();
    core_halt = 1;
    tick();
    core_halt = 0;
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_ready", host_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_oe", bus_oe, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_cksum", checksum, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    prog = '{16'h1105, 16'h122A, 16'h0000};
    load(3, 0);
`ifdef HMMM_LOADER_CKSUM_EN
    chk("cksum_vector", checksum, 16'h232F);
`endif
    run_random(40);
    core_read = 1;
    in_valid = 1;
    in_data = 16'h002A;
    #1;
    chk("read_oe", bus_oe, 1);
    chk("read_bus", bus_out, 16'h002A);
    chk("read_pop", in_ready, 1);
    in_valid = 0;
    #1;
    chk("uf_bus", bus_out, 0);
    chk("uf_pop", in_ready, 0);
    tick();
    core_read = 0;
    chk("uf_latched", underflow, 1);
    core_write = 1;
    core_halt = 1;
    bus_in = 16'h00FF;
    tick();
    core_write = 0;
    core_halt = 0;
    chk("wh_valid", out_valid, 1);
    chk("wh_data", out_data, 16'h00FF);
    chk("wh_done", done, 1);
    chk("halted_rst", core_rst, 0);
    chk("cksum_held", checksum, exp_ck);
    tick();
    chk("wh_valid_drop", out_valid, 0);
    core_read = 1;
    core_write = 1;
    #1;
    chk("halted_read_ignored", bus_oe, 0);
    tick();
    core_read = 0;
    core_write = 0;
    chk("halted_write_ignored", out_valid, 0);
    chk("uf_sticky", underflow, 1);
    prog.delete();
    load(0, 0);
    chk("len0_uf_clear", underflow, 0);
    halt();
    prog.delete();
    load(300, 1);
    chk("last_addr", aq.size() > 0 ? aq[aq.size()-1] : 16'hFFFF, 16'd255);
    run_random(20);
    halt();
    for (int k = 0; k < 3; k++) begin
      prog.delete();
      load($urandom_range(1, 20), 1);
      run_random(30);
      halt();
    end
    start = 1;
    len = 2;
    tick();
    start = 0;
    host_valid = 1;
    host_data = 16'hBEEF;
    tick();
    host_valid = 0;
    tick();
    chk("pre_rst_data", pgrm_data, 1);
    rst_n = 0;
    #1;
    chk("arst_data", pgrm_data, 0);
    chk("arst_oe", bus_oe, 0);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_ready", host_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
